fb_mem_arbiter: RTL and testbench

- Shares the single frame-buffer SRAM port between up to NUM_REQ drawing engines (fill-rect, line, blit, …).
- Each engine presents one request (addr/data/wben/op) with an rts/rtr handshake.
- Requesters are granted round-robin. Each transaction is executed on the memory port, and completion is broadcast (bcast_data plus a one-hot xfc pulse) back to the requesters.
- Sits between the engine bank and the frame-buffer RAM; exactly one transaction is in flight at a time.

---
 rtl/fb_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_fb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_mem_arbiter.sv
// Round-robin arbiter that shares one synchronous-read frame-buffer SRAM port
// between NUM_REQ drawing engines, one transaction in flight at a time.
module fb_mem_arbiter #(
    parameter int NUM_REQ = 5,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data_i,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr_i,
    input  logic [NUM_REQ*(DATA_W/8)-1:0] req_wben_i,
    input  logic [NUM_REQ-1:0]            req_op_i,
    input  logic [NUM_REQ-1:0]            req_rts_i,
    output logic [NUM_REQ-1:0]            req_rtr_o,
    output logic [DATA_W-1:0]             bcast_data_o,
    output logic [NUM_REQ-1:0]            bcast_xfc_o,
    output logic                          mem_en_o,
    output logic                          mem_we_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [DATA_W-1:0]             mem_wdata_o,
    output logic [DATA_W/8-1:0]           mem_wben_o,
    input  logic [DATA_W-1:0]             mem_rdata_i
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {IDLE, GRANT, MEM, RDWAIT, RESP} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   gnt_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [NUM_REQ-1:0] req_rtr_q;
    logic [NUM_REQ-1:0] bcast_xfc_q;
    logic [DATA_W-1:0]  bcast_data_q;
    logic               mem_en_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic [BE_W-1:0]    mem_wben_q;

    logic [ADDR_W-1:0]  slot_addr [NUM_REQ];
    logic [DATA_W-1:0]  slot_data [NUM_REQ];
    logic [BE_W-1:0]    slot_wben [NUM_REQ];

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
        assign slot_addr[gi] = req_addr_i[ADDR_W*gi +: ADDR_W];
        assign slot_data[gi] = req_data_i[DATA_W*gi +: DATA_W];
        assign slot_wben[gi] = req_wben_i[BE_W*gi +: BE_W];
    end

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Walk downward so the candidate closest to ptr is the last one written.
    always_comb begin : arb_search
        int               pos;
        logic [IDX_W-1:0] cand;
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = int'(ptr_q) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cand = IDX_W'(pos);
            if (req_rts_i[cand]) begin
                pick_idx = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            ptr_q        <= '0;
            req_rtr_q    <= '0;
            bcast_xfc_q  <= '0;
            bcast_data_q <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wben_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_q     <= pick_idx;
                        req_rtr_q <= onehot(pick_idx);
                        state_q   <= GRANT;
                    end
                end
                GRANT: begin
                    req_rtr_q <= '0;
                    // A requester that let go of rts before seeing rtr forfeits the slot.
                    if (req_rts_i[gnt_q]) begin
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= req_op_i[gnt_q];
                        mem_addr_q  <= slot_addr[gnt_q];
                        mem_wdata_q <= slot_data[gnt_q];
                        mem_wben_q  <= req_op_i[gnt_q] ? slot_wben[gnt_q] : '0;
                        state_q     <= MEM;
                    end else begin
                        state_q     <= IDLE;
                    end
                end
                MEM: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (mem_we_q) begin
                        bcast_data_q <= mem_wdata_q;
                        bcast_xfc_q  <= onehot(gnt_q);
                        state_q      <= RESP;
                    end else begin
                        state_q      <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    bcast_data_q <= mem_rdata_i;
                    bcast_xfc_q  <= onehot(gnt_q);
                    state_q      <= RESP;
                end
                RESP: begin
                    bcast_xfc_q <= '0;
                    ptr_q       <= ptr_d;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_rtr_o    = req_rtr_q;
    assign bcast_xfc_o  = bcast_xfc_q;
    assign bcast_data_o = bcast_data_q;
    assign mem_en_o     = mem_en_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_wben_o   = mem_wben_q;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Bench for fb_mem_arbiter: vector table of single transactions, multi-requester
// arbitration sequences and reset/abort corners, with a completion scoreboard.
module tb_fb_mem_arbiter;
    localparam int NUM_REQ = 5;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int BE_W    = DATA_W / 8;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ*BE_W-1:0]   req_wben = '0;
    logic [NUM_REQ-1:0]        req_op   = '0;
    logic [NUM_REQ-1:0]        req_rts  = '0;
    logic [NUM_REQ-1:0]        req_rtr;
    logic [DATA_W-1:0]         bcast_data;
    logic [NUM_REQ-1:0]        bcast_xfc;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [BE_W-1:0]           mem_wben;
    logic [DATA_W-1:0]         mem_rdata = '0;

    fb_mem_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_data_i  (req_data),
        .req_addr_i  (req_addr),
        .req_wben_i  (req_wben),
        .req_op_i    (req_op),
        .req_rts_i   (req_rts),
        .req_rtr_o   (req_rtr),
        .bcast_data_o(bcast_data),
        .bcast_xfc_o (bcast_xfc),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_wben_o  (mem_wben),
        .mem_rdata_i (mem_rdata)
    );

    always #5 clk = ~clk;

    // Frame-buffer RAM model: byte-enabled write, one-cycle synchronous read.
    logic [DATA_W-1:0] ram [0:255];
    initial for (int i = 0; i < 256; i++) ram[i] = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < BE_W; b++)
                    if (mem_wben[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[7:0]];
            end
        end
    end

    typedef struct {
        int          slot;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        int          slot;
        bit          op;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  wben;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[8];

    int total = 0;
    int bad   = 0;
    int rem_cfg[NUM_REQ];
    int ord_cfg[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Completion monitor: every xfc pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if ($countones(req_rtr) > 1 || $countones(bcast_xfc) > 1) begin
                bad++;
                $display("FAIL onehot rtr=%b xfc=%b", req_rtr, bcast_xfc);
            end
            if (bcast_xfc != '0) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_xfc xfc=%b data=%h", bcast_xfc, bcast_data);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (bcast_xfc !== (NUM_REQ'(1) << e.slot) || bcast_data !== e.data) begin
                        bad++;
                        $display("FAIL completion xfc=%b data=%h want_xfc=%b want_data=%h",
                                 bcast_xfc, bcast_data, NUM_REQ'(1) << e.slot, e.data);
                    end else begin
                        $display("txn done slot=%0d data=%h", e.slot, bcast_data);
                    end
                end
            end
        end
    end

    task automatic set_slot(input int s, input bit op, input logic [15:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        req_op[s]                    = op;
        req_addr[ADDR_W*s +: ADDR_W] = a;
        req_data[DATA_W*s +: DATA_W] = d;
        req_wben[BE_W*s +: BE_W]     = be;
    endtask

    task automatic run_txn(input vec_t v);
        int n;
        @(negedge clk);
        set_slot(v.slot, v.op, v.addr, v.data, v.wben);
        req_rts[v.slot] = 1'b1;
        sb_q.push_back('{v.slot, v.exp});
        n = 0;
        do begin @(negedge clk); n++; end while (!req_rtr[v.slot] && n < 20);
        chk("rtr_latency", 64'(n), 64'd1);
        chk("rtr_onehot", 64'(req_rtr), 64'(NUM_REQ'(1) << v.slot));
        @(negedge clk); n++;
        req_rts[v.slot] = 1'b0;
        chk("mem_en", 64'(mem_en), 64'd1);
        chk("mem_we", 64'(mem_we), 64'(v.op));
        chk("mem_addr", 64'(mem_addr), 64'(v.addr));
        chk("mem_wben", 64'(mem_wben), v.op ? 64'(v.wben) : 64'd0);
        if (v.op) chk("mem_wdata", 64'(mem_wdata), 64'(v.data));
        do begin @(negedge clk); n++; end while (!bcast_xfc[v.slot] && n < 20);
        chk("xfc_latency", 64'(n), v.op ? 64'd3 : 64'd4);
    endtask

    // Holds rts per slot until it has been granted rem_cfg[slot] times.
    task automatic run_multi(input int n_exp, input logic [3:0] exp_wben);
        int rem[NUM_REQ];
        int got[$];
        int cyc;
        int w;
        bit busy;
        rem  = rem_cfg;
        cyc  = 0;
        busy = 1'b1;
        while (busy && cyc < 300) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NUM_REQ; i++) req_rts[i] = (rem[i] > 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_rtr[i]) begin
                    got.push_back(i);
                    if (rem[i] > 0) rem[i]--;
                end
            end
            if (mem_en && mem_we) chk("multi_wben", 64'(mem_wben), 64'(exp_wben));
            busy = (req_rts != '0);
            for (int i = 0; i < NUM_REQ; i++) if (rem[i] > 0) busy = 1'b1;
        end
        req_rts = '0;
        chk("grant_count", 64'(got.size()), 64'(n_exp));
        for (int k = 0; k < n_exp; k++)
            chk("grant_order", (k < got.size()) ? 64'(got[k]) : 64'hFFFF, 64'(ord_cfg[k]));
        w = 0;
        while (sb_q.size() != 0 && w < 50) begin @(negedge clk); w++; end
        chk("scoreboard_drain", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rtr"}, 64'(req_rtr), 64'd0);
        chk({tag, "_xfc"}, 64'(bcast_xfc), 64'd0);
        chk({tag, "_bdata"}, 64'(bcast_data), 64'd0);
        chk({tag, "_mem_en"}, 64'(mem_en), 64'd0);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_mem_wben"}, 64'(mem_wben), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{1, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
        vecs[1] = '{1, 1'b0, 16'h0010, 32'h0,        4'hF, 32'hDEADBEEF};
        vecs[2] = '{0, 1'b1, 16'h0020, 32'h11223344, 4'hF, 32'h11223344};
        vecs[3] = '{2, 1'b1, 16'h0021, 32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5};
        vecs[4] = '{3, 1'b1, 16'h0020, 32'hFFFFFFFF, 4'h5, 32'hFFFFFFFF};
        vecs[5] = '{4, 1'b0, 16'h0020, 32'h0,        4'hF, 32'h11FF33FF};
        vecs[6] = '{2, 1'b0, 16'h0021, 32'h0,        4'hF, 32'hA5A5A5A5};
        vecs[7] = '{0, 1'b0, 16'h1233, 32'h0,        4'hF, 32'h00000000};

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Round-robin from ptr=0 with slots 0,1,3 always requesting.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < NUM_REQ; s++) set_slot(s, 1'b1, 16'h0040 + 16'(s), 32'hC0DE0000 + 32'(s), 4'hF);
        rem_cfg = '{2, 2, 0, 2, 0};
        ord_cfg = '{0, 1, 3, 0, 1, 3, 0, 0};
        for (int k = 0; k < 6; k++) sb_q.push_back('{ord_cfg[k], 32'hC0DE0000 + 32'(ord_cfg[k])});
        run_multi(6, 4'hF);

        // Wrap: ptr is now 4, slots 4 (read) and 0 (partial write) compete.
        set_slot(4, 1'b0, 16'h0051, 32'h0, 4'hF);
        set_slot(0, 1'b1, 16'h0051, 32'h12345678, 4'b0011);
        rem_cfg = '{1, 0, 0, 0, 1};
        ord_cfg = '{4, 0, 0, 0, 0, 0, 0, 0};
        sb_q.push_back('{4, 32'h00000000});
        sb_q.push_back('{0, 32'h12345678});
        run_multi(2, 4'b0011);
        run_txn('{0, 1'b0, 16'h0051, 32'h0, 4'hF, 32'h00005678});

        // Aborted grant on slot 2; ptr stays 1 so slot 2 must win over slot 3.
        @(negedge clk);
        set_slot(2, 1'b1, 16'h0060, 32'hBAD0BAD0, 4'hF);
        req_rts[2] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_rtr[2] && n < 20);
        chk("abort_rtr_latency", 64'(n), 64'd1);
        req_rts[2] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_no_mem_en", 64'(mem_en), 64'd0);
            chk("abort_no_xfc", 64'(bcast_xfc), 64'd0);
        end
        set_slot(2, 1'b1, 16'h0060, 32'h22220002, 4'hF);
        set_slot(3, 1'b1, 16'h0061, 32'h33330003, 4'hF);
        rem_cfg = '{0, 0, 1, 1, 0};
        ord_cfg = '{2, 3, 0, 0, 0, 0, 0, 0};
        sb_q.push_back('{2, 32'h22220002});
        sb_q.push_back('{3, 32'h33330003});
        run_multi(2, 4'hF);

        // Reset during RDWAIT of a slot-1 read; ptr was 4 beforehand.
        @(negedge clk);
        set_slot(1, 1'b0, 16'h0010, 32'h0, 4'hF);
        req_rts[1] = 1'b1;
        @(negedge clk);
        chk("rstmid_rtr", 64'(req_rtr), 64'b00010);
        @(negedge clk);
        chk("rstmid_mem_en", 64'(mem_en), 64'd1);
        req_rts[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("rstmid");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rstmid_no_xfc", 64'(bcast_xfc), 64'd0);
        end
        set_slot(3, 1'b1, 16'h0070, 32'h77770003, 4'hF);
        set_slot(4, 1'b1, 16'h0071, 32'h77770004, 4'hF);
        rem_cfg = '{0, 0, 0, 1, 1};
        ord_cfg = '{3, 4, 0, 0, 0, 0, 0, 0};
        sb_q.push_back('{3, 32'h77770003});
        sb_q.push_back('{4, 32'h77770004});
        run_multi(2, 4'hF);

        repeat (3) @(negedge clk);
        chk("final_scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
